// File: rtl/player_motion_sequencer.sv
// Per-frame player pose sequencer: rotate, fetch sin/cos, propose a step, ask the collision checker, commit.
// Optional PLAYER_WALL_SLIDE_EN: a blocked step is retried as an x-only move, then a y-only move.
module player_motion_sequencer #(
  parameter int ROTATE_SPEED  = 1,
  parameter int FORWARD_SPEED = 5,
  parameter int X_MAX         = 639,
  parameter int Y_MAX         = 479,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        key_forward,
  input  logic        key_left,
  input  logic        key_right,
  output logic        trig_req,
  output logic [8:0]  trig_angle,
  input  logic        trig_ack,
  input  logic [15:0] trig_cos,
  input  logic [15:0] trig_sin,
  output logic        coll_req,
  output logic [15:0] coll_x,
  output logic [15:0] coll_y,
  input  logic        coll_ack,
  input  logic        coll_hit,
  output logic [15:0] x_position,
  output logic [15:0] y_position,
  output logic [8:0]  angle,
  output logic        busy,
  output logic        update_done,
  output logic        overrun
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [23:0] X_LIM = 24'(X_MAX * 256);
  localparam logic [23:0] Y_LIM = 24'(Y_MAX * 256);
  localparam logic [9:0] ROT = 10'(ROTATE_SPEED);
  localparam logic signed [24:0] FWD = 25'(FORWARD_SPEED);

  typedef enum logic [2:0] {IDLE, ROTATE, TRIG, MOVE, CHECK} state_t;

  state_t state, state_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic done_q, done_next;
  logic overrun_q;
  logic commit_x, commit_y;
  logic fwd_l, left_l, right_l;
  logic [8:0] angle_q, angle_next, angle_cw, angle_ccw;
  logic [9:0] rot_sum;
  logic [23:0] x_q, y_q, px_q, py_q;
  logic signed [15:0] cos_q, sin_q;
  logic signed [24:0] cos_ext, sin_ext, prod_x, prod_y, dx, dy, px_raw, py_raw;

`ifdef PLAYER_WALL_SLIDE_EN
  logic [1:0] stage_q, stage_next;
`endif

  // Negative proposals pin to the map origin, large ones to the far edge.
  function automatic logic [23:0] clamp(input logic signed [24:0] v, input logic [23:0] lim);
    if (v < 0)
      return 24'd0;
    else if (v > $signed({1'b0, lim}))
      return lim;
    else
      return v[23:0];
  endfunction

  assign rot_sum   = {1'b0, angle_q} + ROT;
  assign angle_cw  = (rot_sum >= 10'd360) ? 9'(rot_sum - 10'd360) : rot_sum[8:0];
  assign angle_ccw = ({1'b0, angle_q} >= ROT) ? 9'({1'b0, angle_q} - ROT)
                                              : 9'({1'b0, angle_q} + 10'd360 - ROT);

  assign cos_ext = {{9{cos_q[15]}}, cos_q};
  assign sin_ext = {{9{sin_q[15]}}, sin_q};
  assign prod_x  = cos_ext * FWD;
  assign prod_y  = sin_ext * FWD;
  assign dx      = prod_x >>> 6;
  assign dy      = prod_y >>> 6;
  assign px_raw  = $signed({1'b0, x_q}) + dx;
  assign py_raw  = $signed({1'b0, y_q}) + dy;

  always_comb begin
    state_next = state;
    cnt_next   = '0;
    done_next  = 1'b0;
    commit_x   = 1'b0;
    commit_y   = 1'b0;
    angle_next = angle_q;
`ifdef PLAYER_WALL_SLIDE_EN
    stage_next = stage_q;
`endif
    case (state)
      IDLE: begin
        if (frame_tick)
          state_next = ROTATE;
      end
      ROTATE: begin
        if (right_l && !left_l)
          angle_next = angle_cw;
        else if (left_l && !right_l)
          angle_next = angle_ccw;
        if (fwd_l) begin
          state_next = TRIG;
        end else begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      TRIG: begin
        if (trig_ack) begin
          state_next = MOVE;
        end else if (cnt_q == CNT_LAST) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_q + CNT_W'(1);
        end
      end
      MOVE: begin
        state_next = CHECK;
`ifdef PLAYER_WALL_SLIDE_EN
        stage_next = 2'd0;
`endif
      end
      CHECK: begin
        if (coll_ack) begin
`ifdef PLAYER_WALL_SLIDE_EN
          // Stage 0 tries the full step, 1 the x component, 2 the y component.
          if (!coll_hit) begin
            commit_x   = (stage_q != 2'd2);
            commit_y   = (stage_q != 2'd1);
            state_next = IDLE;
            done_next  = 1'b1;
          end else if (stage_q != 2'd2) begin
            stage_next = stage_q + 2'd1;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
`else
          commit_x   = !coll_hit;
          commit_y   = !coll_hit;
          state_next = IDLE;
          done_next  = 1'b1;
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_q + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PLAYER_WALL_SLIDE_EN
      stage_q   <= 2'd0;
`endif
    end else begin
      state  <= state_next;
      cnt_q  <= cnt_next;
      done_q <= done_next;
`ifdef PLAYER_WALL_SLIDE_EN
      stage_q <= stage_next;
`endif
      if (frame_tick && state != IDLE)
        overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_l   <= 1'b0;
      left_l  <= 1'b0;
      right_l <= 1'b0;
      angle_q <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      if (state == IDLE && frame_tick) begin
        fwd_l   <= key_forward;
        left_l  <= key_left;
        right_l <= key_right;
      end
      angle_q <= angle_next;
      if (state == TRIG && trig_ack) begin
        cos_q <= trig_cos;
        sin_q <= trig_sin;
      end
      if (state == MOVE) begin
        px_q <= clamp(px_raw, X_LIM);
        py_q <= clamp(py_raw, Y_LIM);
      end
      if (commit_x)
        x_q <= px_q;
      if (commit_y)
        y_q <= py_q;
    end
  end

`ifdef PLAYER_WALL_SLIDE_EN
  assign coll_x = (stage_q == 2'd2) ? x_q[23:8] : px_q[23:8];
  assign coll_y = (stage_q == 2'd1) ? y_q[23:8] : py_q[23:8];
`else
  assign coll_x = px_q[23:8];
  assign coll_y = py_q[23:8];
`endif

  assign trig_req    = (state == TRIG);
  assign coll_req    = (state == CHECK);
  assign trig_angle  = angle_q;
  assign angle       = angle_q;
  assign x_position  = x_q[23:8];
  assign y_position  = y_q[23:8];
  assign busy        = (state != IDLE);
  assign update_done = done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_player_motion_sequencer.sv
// Scoreboard bench for player_motion_sequencer: a pose model predicts each frame, results checked at update_done.
// Wall-slide scenarios are compiled in when PLAYER_WALL_SLIDE_EN is defined.
module tb_player_motion_sequencer;

  localparam int ROT = 1;
  localparam int FWD = 5;
  localparam int XLIM = 639 * 256;
  localparam int YLIM = 479 * 256;
  localparam int TMO = 255;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0, key_forward = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic trig_req, trig_ack = 1'b0;
  logic [8:0] trig_angle, angle;
  logic [15:0] trig_cos = '0, trig_sin = '0;
  logic coll_req, coll_ack = 1'b0, coll_hit = 1'b0;
  logic [15:0] coll_x, coll_y, x_position, y_position;
  logic busy, update_done, overrun;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int x;
    int y;
    int ang;
    int cx;
    int cy;
    int done;
  } exp_t;
  exp_t exp_q[$];

  int mx = 0, my = 0, mang = 0;
  int done_cyc, trig_cycles, nchk;
  logic [8:0] trig_ang_obs;
  logic [15:0] obs_cx [3];
  logic [15:0] obs_cy [3];
  logic req_after;

  player_motion_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .key_forward(key_forward), .key_left(key_left), .key_right(key_right),
    .trig_req(trig_req), .trig_angle(trig_angle), .trig_ack(trig_ack),
    .trig_cos(trig_cos), .trig_sin(trig_sin),
    .coll_req(coll_req), .coll_x(coll_x), .coll_y(coll_y),
    .coll_ack(coll_ack), .coll_hit(coll_hit),
    .x_position(x_position), .y_position(y_position), .angle(angle),
    .busy(busy), .update_done(update_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic int clampi(input int v, input int lim);
    if (v < 0) return 0;
    if (v > lim) return lim;
    return v;
  endfunction

  // Model of one frame; pushes the expected outcome before the DUT sees the tick.
  task automatic predict(input bit f, input bit l, input bit r, input int c, input int s,
                         input bit [2:0] hits, input bit trig_ok);
    exp_t e;
    int px, py;
    if (r && !l) mang = (mang + ROT) % 360;
    else if (l && !r) mang = (mang + 360 - ROT) % 360;
    e.cx = -1;
    e.cy = -1;
    e.done = !f ? 2 : (trig_ok ? 5 : 2 + TMO);
    if (f && trig_ok) begin
      px = clampi(mx + ((FWD * c) >>> 6), XLIM);
      py = clampi(my + ((FWD * s) >>> 6), YLIM);
      e.cx = px >> 8;
      e.cy = py >> 8;
`ifdef PLAYER_WALL_SLIDE_EN
      if (!hits[0]) begin mx = px; my = py; end
      else if (!hits[1]) begin mx = px; e.done = 6; end
      else if (!hits[2]) begin my = py; e.done = 7; end
      else e.done = 7;
`else
      if (!hits[0]) begin mx = px; my = py; end
`endif
    end
    e.x = mx;
    e.y = my;
    e.ang = mang;
    exp_q.push_back(e);
  endtask

  // Drives one frame from a negedge and plays the trig and collision units until update_done.
  task automatic run_frame(input bit f, input bit l, input bit r, input int trig_lat,
                           input logic [15:0] c, input logic [15:0] s,
                           input bit [2:0] hits, input bit tick_mid);
    int cyc, tw;
    bit ticked;
    nchk = 0; trig_cycles = 0; done_cyc = -1; req_after = 1'b0; tw = 0; ticked = 1'b0;
    key_forward = f; key_left = l; key_right = r; frame_tick = 1'b1;
    @(negedge clk);
    key_forward = !f; key_left = !l; key_right = !r;
    cyc = 1;
    while (cyc < 1000) begin
      frame_tick = 1'b0; trig_ack = 1'b0; coll_ack = 1'b0; coll_hit = 1'b0;
      if (update_done) begin
        done_cyc = cyc;
        req_after = trig_req | coll_req;
        break;
      end
      if (trig_req) begin
        trig_cycles++;
        trig_ang_obs = trig_angle;
        if (trig_lat >= 0 && tw == trig_lat) begin
          trig_ack = 1'b1; trig_cos = c; trig_sin = s;
        end
        tw++;
      end
      if (coll_req) begin
        if (tick_mid && !ticked) begin
          frame_tick = 1'b1;
          ticked = 1'b1;
        end else if (nchk < 3) begin
          obs_cx[nchk] = coll_x; obs_cy[nchk] = coll_y;
          coll_ack = 1'b1; coll_hit = hits[nchk];
          nchk++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    key_forward = 1'b0; key_left = 1'b0; key_right = 1'b0;
    frame_tick = 1'b0; trig_ack = 1'b0; coll_ack = 1'b0; coll_hit = 1'b0;
    if (done_cyc < 0) begin
      checks++; failures++;
      $display("[TB] FAIL frame_bound got=no_update_done exp=update_done_within_1000");
    end
  endtask

  task automatic frame(input bit f, input bit l, input bit r, input int trig_lat,
                       input int c, input int s, input bit [2:0] hits, input bit tick_mid);
    predict(f, l, r, c, s, hits, trig_lat >= 0);
    run_frame(f, l, r, trig_lat, 16'(c), 16'(s), hits, tick_mid);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({trig_req, coll_req, busy, update_done, overrun} !== 5'b0) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=00000", {trig_req, coll_req, busy, update_done, overrun}); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({x_position, y_position} !== 32'd0) begin failures++; $display("[TB] FAIL reset_pos got=%h exp=0", {x_position, y_position}); end
    checks++; if (angle !== 9'd0 || trig_angle !== 9'd0) begin failures++; $display("[TB] FAIL reset_angle got=%0d/%0d exp=0", angle, trig_angle); end
    checks++; if ({coll_x, coll_y} !== 32'd0) begin failures++; $display("[TB] FAIL reset_coll got=%h exp=0", {coll_x, coll_y}); end
    checks++; if ({trig_req, coll_req, busy, update_done, overrun} !== 5'b0) begin failures++; $display("[TB] FAIL idle_flags got=%b exp=00000", {trig_req, coll_req, busy, update_done, overrun}); end
  endtask

  task automatic test_no_keys();
    exp_t e;
    frame(0, 0, 0, 0, 0, 0, 3'b000, 0);
    e = exp_q.pop_front();
    checks++; if (done_cyc !== e.done) begin failures++; $display("[TB] FAIL nokey_latency got=%0d exp=%0d", done_cyc, e.done); end
    checks++; if (trig_cycles !== 0) begin failures++; $display("[TB] FAIL nokey_trig got=%0d exp=0", trig_cycles); end
    checks++; if (angle !== 9'(e.ang)) begin failures++; $display("[TB] FAIL nokey_angle got=%0d exp=%0d", angle, e.ang); end
  endtask

  task automatic test_ack_ignored();
    logic saw_busy;
    saw_busy = 1'b0;
    trig_ack = 1'b1; coll_ack = 1'b1; coll_hit = 1'b0; trig_cos = 16'sd16384;
    repeat (3) begin
      @(negedge clk);
      saw_busy |= busy;
    end
    trig_ack = 1'b0; coll_ack = 1'b0;
    checks++; if (saw_busy !== 1'b0 || update_done !== 1'b0) begin failures++; $display("[TB] FAIL stray_ack got=busy%b/done%b exp=0/0", saw_busy, update_done); end
    checks++; if (x_position !== 16'd0) begin failures++; $display("[TB] FAIL stray_ack_pos got=%0d exp=0", x_position); end
  endtask

  task automatic test_build_position();
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      frame(1, 0, 0, 0, 16384, 16384, 3'b000, 0);
      e = exp_q.pop_front();
      checks++; if (done_cyc !== e.done) begin failures++; $display("[TB] FAIL build_latency%0d got=%0d exp=%0d", i, done_cyc, e.done); end
      checks++; if (x_position !== 16'(e.x >> 8) || y_position !== 16'(e.y >> 8)) begin failures++; $display("[TB] FAIL build_pos%0d got=%0d,%0d exp=%0d,%0d", i, x_position, y_position, e.x >> 8, e.y >> 8); end
    end
    checks++; if (x_position !== 16'd100 || y_position !== 16'd100) begin failures++; $display("[TB] FAIL build_final got=%0d,%0d exp=100,100", x_position, y_position); end
  endtask

  task automatic test_forward();
    exp_t e;
    frame(1, 0, 0, 0, 16384, 0, 3'b000, 0);
    e = exp_q.pop_front();
    checks++; if (obs_cx[0] !== 16'd105 || obs_cy[0] !== 16'd100) begin failures++; $display("[TB] FAIL fwd_coll got=%0d,%0d exp=105,100", obs_cx[0], obs_cy[0]); end
    checks++; if (x_position !== 16'(e.x >> 8) || y_position !== 16'd100) begin failures++; $display("[TB] FAIL fwd_commit got=%0d,%0d exp=%0d,100", x_position, y_position, e.x >> 8); end
    checks++; if (trig_ang_obs !== 9'd0 || req_after !== 1'b0) begin failures++; $display("[TB] FAIL fwd_trig got=ang%0d/req%b exp=0/0", trig_ang_obs, req_after); end
  endtask

  task automatic test_rotation();
    exp_t e;
    frame(0, 1, 0, 0, 0, 0, 3'b000, 0);
    e = exp_q.pop_front();
    checks++; if (angle !== 9'd359 || angle !== 9'(e.ang)) begin failures++; $display("[TB] FAIL rot_left_wrap got=%0d exp=359", angle); end
    frame(0, 0, 1, 0, 0, 0, 3'b000, 0);
    e = exp_q.pop_front();
    checks++; if (angle !== 9'd0 || angle !== 9'(e.ang)) begin failures++; $display("[TB] FAIL rot_right_wrap got=%0d exp=0", angle); end
    frame(0, 1, 1, 0, 0, 0, 3'b000, 0);
    e = exp_q.pop_front();
    checks++; if (angle !== 9'(e.ang)) begin failures++; $display("[TB] FAIL rot_both got=%0d exp=%0d", angle, e.ang); end
  endtask

  task automatic test_clamp_low();
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      frame(1, 0, 0, 0, -16384, 0, 3'b000, 0);
      e = exp_q.pop_front();
    end
    frame(1, 0, 0, 0, -9830, 0, 3'b000, 0);
    e = exp_q.pop_front();
    checks++; if (x_position !== 16'd2 || x_position !== 16'(e.x >> 8)) begin failures++; $display("[TB] FAIL back_up got=%0d exp=2", x_position); end
    for (int i = 0; i < 180; i++) begin
      frame(0, 0, 1, 0, 0, 0, 3'b000, 0);
      e = exp_q.pop_front();
    end
    checks++; if (angle !== 9'd180 || angle !== 9'(e.ang)) begin failures++; $display("[TB] FAIL turn_180 got=%0d exp=180", angle); end
    frame(1, 0, 0, 0, -16384, 0, 3'b111, 0);
    e = exp_q.pop_front();
    checks++; if (obs_cx[0] !== 16'd0 || obs_cx[0] !== 16'(e.cx)) begin failures++; $display("[TB] FAIL clamp_zero got=%0d exp=0", obs_cx[0]); end
    checks++; if (x_position !== 16'd2 || y_position !== 16'd100) begin failures++; $display("[TB] FAIL hit_no_move got=%0d,%0d exp=2,100", x_position, y_position); end
    checks++; if (done_cyc !== e.done) begin failures++; $display("[TB] FAIL hit_latency got=%0d exp=%0d", done_cyc, e.done); end
    frame(1, 0, 0, 0, -16384, 0, 3'b000, 0);
    e = exp_q.pop_front();
    checks++; if (x_position !== 16'd0 || x_position !== 16'(e.x >> 8)) begin failures++; $display("[TB] FAIL clamp_commit got=%0d exp=0", x_position); end
  endtask

  task automatic test_clamp_high();
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      frame(1, 0, 0, 0, 0, 32767, 3'b000, 0);
      e = exp_q.pop_front();
      checks++; if (y_position !== 16'(e.y >> 8)) begin failures++; $display("[TB] FAIL climb%0d got=%0d exp=%0d", i, y_position, e.y >> 8); end
    end
    checks++; if (y_position !== 16'd479 || obs_cy[0] !== 16'd479) begin failures++; $display("[TB] FAIL clamp_ymax got=%0d/%0d exp=479", y_position, obs_cy[0]); end
  endtask

`ifdef PLAYER_WALL_SLIDE_EN
  task automatic test_wall_slide();
    exp_t e;
    frame(1, 0, 0, 0, 16384, -16384, 3'b001, 0);
    e = exp_q.pop_front();
    checks++; if (obs_cx[1] !== 16'd5 || obs_cy[1] !== 16'd479) begin failures++; $display("[TB] FAIL slide_x_probe got=%0d,%0d exp=5,479", obs_cx[1], obs_cy[1]); end
    checks++; if (x_position !== 16'(e.x >> 8) || y_position !== 16'd479) begin failures++; $display("[TB] FAIL slide_x_commit got=%0d,%0d exp=%0d,479", x_position, y_position, e.x >> 8); end
    checks++; if (done_cyc !== e.done) begin failures++; $display("[TB] FAIL slide_x_latency got=%0d exp=%0d", done_cyc, e.done); end
    frame(1, 0, 0, 0, 16384, -16384, 3'b011, 0);
    e = exp_q.pop_front();
    checks++; if (obs_cx[2] !== 16'd5 || obs_cy[2] !== 16'd474) begin failures++; $display("[TB] FAIL slide_y_probe got=%0d,%0d exp=5,474", obs_cx[2], obs_cy[2]); end
    checks++; if (x_position !== 16'd5 || y_position !== 16'(e.y >> 8)) begin failures++; $display("[TB] FAIL slide_y_commit got=%0d,%0d exp=5,%0d", x_position, y_position, e.y >> 8); end
  endtask
`endif

  task automatic test_timeout();
    exp_t e;
    frame(1, 0, 1, -1, 16384, 16384, 3'b000, 0);
    e = exp_q.pop_front();
    checks++; if (trig_cycles !== TMO) begin failures++; $display("[TB] FAIL tmo_req_len got=%0d exp=%0d", trig_cycles, TMO); end
    checks++; if (done_cyc !== e.done || req_after !== 1'b0) begin failures++; $display("[TB] FAIL tmo_done got=%0d/req%b exp=%0d/0", done_cyc, req_after, e.done); end
    checks++; if (x_position !== 16'(e.x >> 8) || y_position !== 16'(e.y >> 8)) begin failures++; $display("[TB] FAIL tmo_pos got=%0d,%0d exp=%0d,%0d", x_position, y_position, e.x >> 8, e.y >> 8); end
    checks++; if (angle !== 9'(e.ang)) begin failures++; $display("[TB] FAIL tmo_angle got=%0d exp=%0d", angle, e.ang); end
  endtask

  task automatic test_overrun();
    exp_t e;
    logic saw_busy;
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL overrun_early got=%b exp=0", overrun); end
    frame(1, 0, 0, 0, 16384, 0, 3'b000, 1);
    e = exp_q.pop_front();
    checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_set got=%b exp=1", overrun); end
    checks++; if (x_position !== 16'(e.x >> 8)) begin failures++; $display("[TB] FAIL overrun_commit got=%0d exp=%0d", x_position, e.x >> 8); end
    saw_busy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      saw_busy |= busy;
    end
    checks++; if (saw_busy !== 1'b0) begin failures++; $display("[TB] FAIL overrun_rerun got=%b exp=0", saw_busy); end
    frame(0, 0, 0, 0, 0, 0, 3'b000, 0);
    e = exp_q.pop_front();
    checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    key_forward = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    key_forward = 1'b0; frame_tick = 1'b0;
    while (!trig_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++; if (trig_req !== 1'b1) begin failures++; $display("[TB] FAIL mid_req got=%b exp=1", trig_req); end
    reset = 1'b1;
    #1;
    checks++; if ({trig_req, busy, overrun} !== 3'b000) begin failures++; $display("[TB] FAIL mid_reset got=%b exp=000", {trig_req, busy, overrun}); end
    checks++; if ({x_position, y_position} !== 32'd0) begin failures++; $display("[TB] FAIL mid_reset_pos got=%h exp=0", {x_position, y_position}); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_no_keys();
    test_ack_ignored();
    test_build_position();
    test_forward();
    test_rotation();
    test_clamp_low();
    test_clamp_high();
`ifdef PLAYER_WALL_SLIDE_EN
    test_wall_slide();
`endif
    test_timeout();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
